// File: rtl/led_status_sequencer.sv
// Schedules the single status LED between heartbeat, activity flicker and blink-coded error sources.
// Outputs are registered from the next state (1-cycle latency in HB); err_ready deasserts whenever an error is being shown or err_clear is high.
module led_status_sequencer #(
    parameter int unsigned TICK_DIV  = 5000000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 3,
    parameter int unsigned GAP_TICKS = 10,
    parameter int unsigned ACT_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heartbeat_in,
    input  logic       activity_pulse,
    input  logic       err_valid,
    input  logic [3:0] err_code,
    output logic       err_ready,
    input  logic       err_clear,
    output logic       led_out,
    output logic       busy,
    output logic [1:0] cur_src
);

    typedef enum logic [2:0] {
        ST_HB,
        ST_ACT,
        ST_ERR_ON,
        ST_ERR_OFF,
        ST_ERR_GAP
    } state_t;

    localparam logic [31:0] PRESC_LAST = 32'(TICK_DIV - 1);
    localparam logic [7:0]  ON_LAST    = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST   = 8'(OFF_TICKS - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_TICKS - 1);
    localparam logic [7:0]  ACT_LAST   = 8'(ACT_TICKS - 1);

    state_t      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  blink_q, blink_d;
    logic [3:0]  code_q, code_d;
    logic        led_d, busy_d;
    logic [1:0]  src_d;
    logic        tick;
    logic        accept;

    assign err_ready = ((state_q == ST_HB) || (state_q == ST_ACT)) && !err_clear;
    assign accept    = err_valid && err_ready && (err_code != 4'd0);
    assign tick      = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = tick ? 32'd0 : presc_q + 32'd1;
        phase_d = phase_q;
        blink_d = blink_q;
        code_d  = code_q;

        case (state_q)
            ST_HB, ST_ACT: begin
                if (accept) begin
                    state_d = ST_ERR_ON;
                    code_d  = err_code;
                    blink_d = 4'd1;
                    phase_d = 8'd0;
                    presc_d = 32'd0;
                end else if (activity_pulse) begin
                    // Re-entering ACT restarts the full flicker interval.
                    state_d = ST_ACT;
                    phase_d = 8'd0;
                    presc_d = 32'd0;
                end else if (state_q == ST_ACT && tick) begin
                    if (phase_q == ACT_LAST) begin
                        state_d = ST_HB;
                        phase_d = 8'd0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            ST_ERR_ON: begin
                if (tick) begin
                    if (phase_q == ON_LAST) begin
                        phase_d = 8'd0;
                        state_d = (blink_q == code_q) ? ST_ERR_GAP : ST_ERR_OFF;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            ST_ERR_OFF: begin
                if (tick) begin
                    if (phase_q == OFF_LAST) begin
                        phase_d = 8'd0;
                        blink_d = blink_q + 4'd1;
                        state_d = ST_ERR_ON;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            ST_ERR_GAP: begin
                if (tick) begin
                    if (phase_q == GAP_LAST) begin
                        phase_d = 8'd0;
                        blink_d = 4'd1;
                        state_d = ST_ERR_ON;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_HB;
                phase_d = 8'd0;
            end
        endcase

        if (err_clear) begin
            state_d = ST_HB;
            phase_d = 8'd0;
            blink_d = 4'd0;
        end
    end

    always_comb begin
        led_d  = 1'b0;
        busy_d = 1'b1;
        src_d  = 2'd2;
        case (state_d)
            ST_HB: begin
                led_d  = heartbeat_in;
                busy_d = 1'b0;
                src_d  = 2'd0;
            end
            ST_ACT:    src_d = 2'd1;
            ST_ERR_ON: led_d = 1'b1;
            default:   led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HB;
            presc_q <= 32'd0;
            phase_q <= 8'd0;
            blink_q <= 4'd0;
            code_q  <= 4'd0;
            led_out <= 1'b0;
            busy    <= 1'b0;
            cur_src <= 2'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            code_q  <= code_d;
            led_out <= led_d;
            busy    <= busy_d;
            cur_src <= src_d;
        end
    end

endmodule

// File: tb/tb_led_status_sequencer.sv
// Directed and randomized bench for led_status_sequencer against a timestamp-based LED model.
module tb_led_status_sequencer;

    localparam int TD  = 4;
    localparam int ON  = 2;
    localparam int OFF = 1;
    localparam int GAP = 3;
    localparam int ACT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       heartbeat_in;
    logic       activity_pulse;
    logic       err_valid;
    logic [3:0] err_code;
    logic       err_ready;
    logic       err_clear;
    logic       led_out;
    logic       busy;
    logic [1:0] cur_src;

    led_status_sequencer #(
        .TICK_DIV (TD),
        .ON_TICKS (ON),
        .OFF_TICKS(OFF),
        .GAP_TICKS(GAP),
        .ACT_TICKS(ACT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .heartbeat_in  (heartbeat_in),
        .activity_pulse(activity_pulse),
        .err_valid     (err_valid),
        .err_code      (err_code),
        .err_ready     (err_ready),
        .err_clear     (err_clear),
        .led_out       (led_out),
        .busy          (busy),
        .cur_src       (cur_src)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner (0 HB, 1 ACT, 2 ERR) plus the edge index where the current owner started.
    int mode   = 0;
    int cyc    = 0;
    int act_t0 = 0;
    int err_t0 = 0;
    int err_c  = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // LED level t cycles after a code-c error was accepted, from the blink pattern layout.
    function automatic logic err_led(input int c, input int t);
        int per;
        int m;
        per = (c * ON + (c - 1) * OFF + GAP) * TD;
        m   = t % per;
        for (int k = 0; k < c; k++) begin
            if (m < ON * TD) return 1'b1;
            m -= ON * TD;
            if (k < c - 1) begin
                if (m < OFF * TD) return 1'b0;
                m -= OFF * TD;
            end
        end
        return 1'b0;
    endfunction

    task automatic step(input logic hb, input logic act, input logic v,
                        input logic [3:0] code, input logic clr);
        logic rdy_m;
        logic led_m;
        @(negedge clk);
        heartbeat_in   = hb;
        activity_pulse = act;
        err_valid      = v;
        err_code       = code;
        err_clear      = clr;
        #1;
        rdy_m = (mode != 2) && !clr;
        chk("err_ready", {3'b0, err_ready}, {3'b0, rdy_m});
        @(posedge clk);
        cyc++;
        if (clr) mode = 0;
        else if (v && rdy_m && code != 4'd0) begin
            mode   = 2;
            err_t0 = cyc;
            err_c  = int'(code);
        end else if (act && mode != 2) begin
            mode   = 1;
            act_t0 = cyc;
        end else if (mode == 1 && cyc - act_t0 == ACT * TD) mode = 0;
        led_m = (mode == 0) ? hb : (mode == 1) ? 1'b0 : err_led(err_c, cyc - err_t0);
        #1;
        chk("led_out", {3'b0, led_out}, {3'b0, led_m});
        chk("busy", {3'b0, busy}, {3'b0, logic'(mode != 0)});
        chk("cur_src", {2'b0, cur_src}, 4'(mode));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        heartbeat_in = 1'b0;
        activity_pulse = 1'b0;
        err_valid = 1'b0;
        err_code = 4'd0;
        err_clear = 1'b0;
        #1;
        chk("rst_led", {3'b0, led_out}, 4'd0);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_src", {2'b0, cur_src}, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Zero code handshake: ready, nothing latched.
        step(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        idle(2);

        // Single flicker, then a restart two cycles in.
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(6);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(8);

        // Code 3, full repeat cycle and beyond.
        step(1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        idle(50);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2);

        // Code 3 with activity during ERR_OFF.
        step(1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        idle(9);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(40);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Clear during ERR_GAP while code 5 is offered.
        step(1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        idle(34);
        step(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        step(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        idle(12);

        // Asynchronous reset in the middle of ERR_ON.
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        idle(3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_led", {3'b0, led_out}, 4'd0);
        chk("async_busy", {3'b0, busy}, 4'd0);
        chk("async_src", {2'b0, cur_src}, 4'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        for (int i = 0; i < 6; i++) step(logic'(i % 2), 1'b0, 1'b0, 4'd0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 24) == 0),
                 4'($urandom_range(0, 6)),
                 logic'($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_status_sequencer.md
# led_status_sequencer

Shares the board's single status LED between three sources: the free-running heartbeat level, a short activity flicker, and a blink-coded error indication. It sits between the heartbeat divider and the LED pin and schedules which source owns the LED. A tick prescaler and a per-state phase counter time every interval. Error codes are accepted over a valid/ready handshake.

## Interface
- TICK_DIV, 5000000: clk cycles per tick; ≥2; default gives 100 ms at 50 MHz.
- ON_TICKS, 2: ticks LED is on per error blink; 1..255.
- OFF_TICKS, 3: ticks LED is off between blinks of one code; 1..255.
- GAP_TICKS, 10: ticks LED is off after the last blink, before the code repeats; 1..255.
- ACT_TICKS, 1: ticks LED is forced off per activity flicker; 1..255.
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- heartbeat_in  in  1  heartbeat level from the heartbeat divider.
- activity_pulse  in  1  single-cycle activity event.
- err_valid  in  1  error code offered.
- err_code  in  4  error code; 1..15 = number of blinks; 0 = no error.
- err_ready  out  1  error code can be accepted this cycle.
- err_clear  in  1  abandon the current error indication.
- led_out  out  1  registered LED drive; 1 = lit.
- busy  out  1  LED is not showing the heartbeat (state ≠ HB).
- cur_src  out  2  LED owner: 0 = HB, 1 = ACT, 2 = ERR, 3 = unused.

## Operation
- Prescaler: 32-bit counter, 0..TICK_DIV-1. Tick strobe is asserted when the counter = TICK_DIV-1, and the counter then wraps to 0. The counter is cleared to 0 on entry to ACT and on error acceptance.
- Phase counter: 8 bits. On a tick in a timed state: if phase = N-1, leave the state and set phase to 0; otherwise increment phase. N is that state's *_TICKS value.
- Blink counter: 4 bits. Latched code register: 4 bits.
- States:
  - HB: led_out = heartbeat_in.
  - ACT: LED off.
  - ERR_ON: LED on.
  - ERR_OFF: LED off.
  - ERR_GAP: LED off.
- err_ready = (state is HB or ACT) & ~err_clear.
- Acceptance: err_valid & err_ready & err_code ≠ 0.
  - Latch the code, set blink = 1, go to ERR_ON.
  - Acceptance takes priority over activity in the same cycle.
- err_code = 0 with valid & ready: handshake completes, nothing is latched, no state change.
- Activity:
  - In HB: go to ACT.
  - In ACT: restart ACT (phase and prescaler cleared).
  - In any ERR_* state: dropped, not queued.
- ACT timeout: return to HB.
- ERR_ON timeout: go to ERR_GAP if blink = code; otherwise go to ERR_OFF.
- ERR_OFF timeout: blink increments, go to ERR_ON.
- ERR_GAP timeout: blink = 1, go to ERR_ON. The code repeats indefinitely until err_clear.
- err_clear:
  - From any state, go to HB on the next edge; phase = 0, blink = 0.
  - Overrides every other transition.
  - While err_clear is high, err_ready is 0, so no error is accepted.
- cur_src: 0 in HB, 1 in ACT, 2 in any ERR_* state.
- Reset (asynchronous, at any time, including mid-sequence):
  - state = HB, counters = 0, code = 0.
  - led_out = 0, busy = 0, cur_src = 0.
  - err_ready = 1 once rst deasserts.

## Timing
- led_out, busy and cur_src are registered from the next-state value, so they change on the same edge as the state.
- In HB, led_out follows heartbeat_in with 1-cycle latency.
- Error acceptance at edge E: led_out = 1 from E.
- Duration of each timed state = N × TICK_DIV cycles, because the prescaler restarts at entry:
  - ERR_ON: ON_TICKS × TICK_DIV.
  - ERR_OFF: OFF_TICKS × TICK_DIV.
  - ERR_GAP: GAP_TICKS × TICK_DIV.
  - ACT: ACT_TICKS × TICK_DIV.
- Code C, full cycle = (C·ON_TICKS + (C-1)·OFF_TICKS + GAP_TICKS) × TICK_DIV cycles.
- The ERR_GAP → ERR_ON and ERR_OFF → ERR_ON transitions do not clear the prescaler; it wraps naturally, so timing stays exact.
- err_ready is combinational from state and err_clear. The handshake completes on the edge where valid & ready are both high.

## Test plan
Common parameters for all scenarios: TICK_DIV = 4, ON = 2, OFF = 1, GAP = 3, ACT = 1.

- Reset:
  - Assert rst mid-ERR_ON; led_out, busy and cur_src go to 0 immediately, without waiting for clk.
  - After release, heartbeat_in toggling appears on led_out one cycle later.
- Code 3 accepted at edge E, LED sequence from E:
  - on 8, off 4, on 8, off 4, on 8, off 12, then on again at E+44.
  - busy = 1 and cur_src = 2 throughout.
- Activity in HB: led_out = 0 for exactly 4 cycles, then follows heartbeat_in.
  - A second pulse 2 cycles in extends the off period to 6 cycles total.
- Activity during ERR_OFF: no effect.
  - The sequence is cycle-identical to the code-3 scenario.
- err_clear during ERR_GAP with err_valid held at code 5:
  - err_ready = 0 while err_clear is high.
  - Next edge: state = HB.
  - Following edge: code 5 is accepted and led_out = 1.
- err_code = 0 with err_valid = 1 in HB: err_ready = 1, state stays HB, busy stays 0.
